// File: rtl/ysyx_23060201_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RV32 width codes
// and the error codes reported to write-back.
package ysyx_23060201_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_FUNC3    = 2'b11;

endpackage

// File: rtl/ysyx_23060201_lsu_align.sv
// Combinational byte-lane logic: store mask/data steering, load extraction
// with sign/zero extension, and misalign/illegal-width detection.
module ysyx_23060201_lsu_align
  import ysyx_23060201_lsu_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misalign,
  output logic        bad_func3
);

  logic [31:0] shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    bad_func3 = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);

    // func3[1:0] gives the access width for both signed and unsigned variants
    misalign   = 1'b0;
    wmask      = 4'b1111;
    wdata_lane = wdata;
    case (func3[1:0])
      2'b00: begin
        wmask      = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        misalign   = off[0];
        wmask      = 4'b0011 << off;
        wdata_lane = {2{wdata[15:0]}};
      end
      2'b10: misalign = (off != 2'b00);
      default: ;
    endcase

    shifted = rdata >> {off, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = shifted[15:0];
    case (func3)
      F3_LB:   rdata_ext = 32'(byte_s);
      F3_LBU:  rdata_ext = {24'd0, shifted[7:0]};
      F3_LH:   rdata_ext = 32'(half_s);
      F3_LHU:  rdata_ext = {16'd0, shifted[15:0]};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: accepts one executed instruction, performs the memory
// access over a req/rsp bus (or passes the ALU result) and hands off to WBU.
module ysyx_23060201_lsu
  import ysyx_23060201_lsu_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_func3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [31:0] in_alu_res,
  input  logic [4:0]  in_rd,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_wen,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wmask,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_wen,
  output logic [4:0]  out_waddr,
  output logic [31:0] out_wdata,
  output logic [1:0]  out_err
);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        load_q, store_q;
  logic [2:0]  func3_q;
  logic [31:0] addr_q, wdata_q, res_q;
  logic [4:0]  rd_q;
  logic [1:0]  err_q;

  logic        in_mem, timeout_hit, accept;
  logic [2:0]  f3_sel;
  logic [1:0]  off_sel;
  logic [3:0]  wmask;
  logic [31:0] wdata_lane, rdata_ext;
  logic        misalign, bad_func3;

  assign in_mem      = in_load | in_store;
  assign accept      = (state_q == S_IDLE) && in_valid;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // In IDLE the checks look at the incoming instruction; afterwards at the latched one
  assign f3_sel  = (state_q == S_IDLE) ? in_func3 : func3_q;
  assign off_sel = (state_q == S_IDLE) ? in_addr[1:0] : addr_q[1:0];

  ysyx_23060201_lsu_align u_align (
    .func3      (f3_sel),
    .off        (off_sel),
    .wdata      (wdata_q),
    .rdata      (rsp_rdata),
    .wmask      (wmask),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .misalign   (misalign),
    .bad_func3  (bad_func3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        if (!in_mem || bad_func3 || misalign) state_d = S_DONE;
        else                                  state_d = S_REQ;
      end
      S_REQ: if (req_ready) begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (rsp_valid || timeout_hit) state_d = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Transaction payload; outputs are gated by state so these need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      load_q  <= in_load & ~in_store;
      store_q <= in_store;
      func3_q <= in_func3;
      addr_q  <= in_addr;
      wdata_q <= in_wdata;
      rd_q    <= in_rd;
      res_q   <= in_mem ? 32'd0 : in_alu_res;
      if (!in_mem)        err_q <= ERR_OK;
      else if (bad_func3) err_q <= ERR_FUNC3;
      else if (misalign)  err_q <= ERR_MISALIGN;
      else                err_q <= ERR_OK;
    end else if (state_q == S_WAIT) begin
      if (rsp_valid) begin
        if (load_q) res_q <= rdata_ext;
      end else if (timeout_hit) begin
        err_q <= ERR_TIMEOUT;
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    req_valid = (state_q == S_REQ);
    req_wen   = req_valid & store_q;
    req_addr  = req_valid ? {addr_q[31:2], 2'b00} : 32'd0;
    req_wdata = req_wen ? wdata_lane : 32'd0;
    req_wmask = req_wen ? wmask : 4'b0000;
    out_valid = (state_q == S_DONE);
    out_wen   = out_valid & ~store_q & (rd_q != 5'd0) & (err_q == ERR_OK);
    out_waddr = out_valid ? rd_q : 5'd0;
    out_wdata = out_valid ? res_q : 32'd0;
    out_err   = out_valid ? err_q : ERR_OK;
  end

endmodule
